// File: rtl/disact_pack_pkg.sv
// disact_pack_pkg: shared state encoding, mode constants and width helpers for the activation distributor
package disact_pack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FLAG,
        ST_ACT,
        ST_DONE
    } state_t;

    localparam logic MODE_PACKED   = 1'b0;
    localparam logic MODE_EXPANDED = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    // Width of a popcount that must be able to hold the full block depth
    function automatic int num_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/disact_pack_act_expander.sv
// act_expander: scatters packed nonzero activations back to their flagged lanes, or passes the packed buffer through
module act_expander
    import disact_pack_pkg::*;
#(
    parameter int BLOCK_DEPTH = 32,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                              i_mode,
    input  logic [BLOCK_DEPTH-1:0]            i_flag,
    input  logic [BLOCK_DEPTH*DATA_WIDTH-1:0] i_packed,
    output logic [BLOCK_DEPTH*DATA_WIDTH-1:0] o_act
);

    // Running prefix popcount gives each flagged lane its rank in the packed buffer
    always_comb begin
        int r;
        r = 0;
        o_act = '0;
        for (int i = 0; i < BLOCK_DEPTH; i++) begin
            if (i_mode == MODE_PACKED) begin
                o_act[i*DATA_WIDTH +: DATA_WIDTH] = i_packed[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (i_flag[i]) begin
                o_act[i*DATA_WIDTH +: DATA_WIDTH] = i_packed[r*DATA_WIDTH +: DATA_WIDTH];
                r = r + 1;
            end
        end
    end

endmodule

// File: rtl/disact_pack.sv
// disact_pack: fetches a sparsity flag word and its compressed activation words and presents one block to the PE array
module disact_pack
    import disact_pack_pkg::*;
#(
    parameter int BLOCK_DEPTH = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int RD_WORDS    = 4,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_mode,
    input  logic                               addr_clr,
    input  logic                               ctrl_fetch,
    output logic                               disact_rdy,
    output logic [BLOCK_DEPTH-1:0]             disact_flg,
    output logic [num_w(BLOCK_DEPTH)-1:0]      disact_num,
    output logic [BLOCK_DEPTH*DATA_WIDTH-1:0]  disact_act,
    output logic                               err_fetch_busy,
    input  logic                               gbfact_val,
    output logic                               gbfact_en_rd,
    output logic [ADDR_WIDTH-1:0]              gbfact_addr_rd,
    input  logic [RD_WORDS*DATA_WIDTH-1:0]     gbfact_dat_rd,
    input  logic                               gbfflg_val,
    output logic                               gbfflg_en_rd,
    output logic [ADDR_WIDTH-1:0]              gbfflg_addr_rd,
    input  logic [BLOCK_DEPTH-1:0]             gbfflg_dat_rd
);

    localparam int NW = num_w(BLOCK_DEPTH);

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [BLOCK_DEPTH-1:0]            r_flg;
    logic [NW-1:0]                     r_num;
    logic [NW-1:0]                     r_need;
    logic [NW-1:0]                     r_issued;
    logic [NW-1:0]                     r_recv;
    logic                              r_pend;
    logic                              r_mode;
    logic                              r_mode_smp;
    logic                              r_err;
    logic [ADDR_WIDTH-1:0]             r_act_addr;
    logic [ADDR_WIDTH-1:0]             r_flg_addr;
    logic [BLOCK_DEPTH*DATA_WIDTH-1:0] r_packed;
    logic                              w_vals;
    logic                              w_flg_rd;
    logic                              w_act_rd;
    logic                              w_busy;
    logic                              w_last;
    logic [NW-1:0]                     w_num;
    logic [NW-1:0]                     w_need;

    assign w_vals = gbfact_val && gbfflg_val;
    assign w_num  = NW'($countones(gbfflg_dat_rd));
    assign w_need = NW'((int'(w_num) + RD_WORDS - 1) / RD_WORDS);
    assign w_last = r_pend && (r_recv == r_need - NW'(1));

    // Next state plus the read strobes and busy-fetch detection
    always_comb begin
        w_state_nxt = r_state;
        w_flg_rd    = 1'b0;
        w_act_rd    = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: w_state_nxt = ctrl_fetch ? ST_CHECK : ST_IDLE;
            ST_CHECK: begin
                w_flg_rd    = w_vals;
                w_busy      = ctrl_fetch;
                w_state_nxt = w_vals ? ST_FLAG : ST_CHECK;
            end
            ST_FLAG: begin
                w_busy      = ctrl_fetch;
                w_state_nxt = (w_num == '0) ? ST_DONE : ST_ACT;
            end
            ST_ACT: begin
                w_act_rd    = (r_issued < r_need) && gbfact_val;
                w_busy      = ctrl_fetch;
                w_state_nxt = w_last ? ST_DONE : ST_ACT;
            end
            ST_DONE: w_state_nxt = ctrl_fetch ? ST_CHECK : ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Read addresses advance per strobe; a clear wins over the increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_addr <= '0;
            r_flg_addr <= '0;
        end else begin
            r_act_addr <= addr_clr ? '0 : r_act_addr + ADDR_WIDTH'(w_act_rd);
            r_flg_addr <= addr_clr ? '0 : r_flg_addr + ADDR_WIDTH'(w_flg_rd);
        end
    end

    // Block datapath: latch flag word, then capture returned words into the packed buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flg      <= '0;
            r_num      <= '0;
            r_need     <= '0;
            r_issued   <= '0;
            r_recv     <= '0;
            r_pend     <= 1'b0;
            r_mode     <= MODE_PACKED;
            r_mode_smp <= MODE_PACKED;
            r_err      <= 1'b0;
            r_packed   <= '0;
        end else begin
            r_pend <= w_act_rd;
            r_err  <= r_err | w_busy;
            if (w_flg_rd) r_mode_smp <= cfg_mode;
            if (r_state == ST_FLAG) begin
                r_flg    <= gbfflg_dat_rd;
                r_num    <= w_num;
                r_need   <= w_need;
                r_issued <= '0;
                r_recv   <= '0;
                r_mode   <= r_mode_smp;
                r_packed <= '0;
            end else begin
                if (w_act_rd) r_issued <= r_issued + NW'(1);
                if (r_pend) begin
                    r_recv <= r_recv + NW'(1);
                    for (int j = 0; j < RD_WORDS; j++)
                        if (int'(r_recv) * RD_WORDS + j < int'(r_num))
                            r_packed[(int'(r_recv)*RD_WORDS + j)*DATA_WIDTH +: DATA_WIDTH]
                                <= gbfact_dat_rd[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    act_expander #(
        .BLOCK_DEPTH (BLOCK_DEPTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_act_expander (
        .i_mode   (r_mode),
        .i_flag   (r_flg),
        .i_packed (r_packed),
        .o_act    (disact_act)
    );

    assign disact_rdy     = (r_state == ST_DONE);
    assign disact_flg     = r_flg;
    assign disact_num     = r_num;
    assign err_fetch_busy = r_err;
    assign gbfact_en_rd   = w_act_rd;
    assign gbfact_addr_rd = r_act_addr;
    assign gbfflg_en_rd   = w_flg_rd;
    assign gbfflg_addr_rd = r_flg_addr;

endmodule
